clock_set_ctrl: RTL and testbench

//   Mode/setting controller for the 24h HH:MM:SS clock datapath on the 50 MHz board clock.

---
 rtl/clock_set_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Mode/setting controller for the 24h HH:MM:SS clock: key debounce, RUN/SET cycle,
// 1 Hz tick, single-cycle field load strobes and blink flags for the field being edited.
module clock_set_ctrl #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_HALF      = 12_500_000,
  parameter int TIMEOUT_S       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  input  logic       key_dec_n,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [1:0] mode,
  output logic       tick_1hz,
  output logic       load_en,
  output logic [1:0] load_sel,
  output logic [5:0] load_val,
  output logic [2:0] blank
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HOUR = 2'b01,
    ST_MIN  = 2'b10,
    ST_SEC  = 2'b11
  } state_t;

  localparam int PW = $clog2(CLK_HZ + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int TW = $clog2(TIMEOUT_S + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [TW-1:0] SEC_LAST   = TW'(TIMEOUT_S - 1);

  // Key order: 0 = mode, 1 = inc, 2 = dec
  logic [2:0] key_raw_n;
  logic [2:0] key_evt;

  assign key_raw_n = {key_dec_n, key_inc_n, key_mode_n};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_key
      logic          sync1_q;
      logic          sync2_q;
      logic          lvl_q;
      logic          armed_q;
      logic          evt_q;
      logic [DW-1:0] cnt_q;
      logic          pressed;

      assign pressed = ~sync2_q;

      // Synchronisers reset to "pressed" so a key held through reset cannot look like
      // a fresh press; armed_q only rises once a released sample has actually been seen.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          lvl_q   <= 1'b0;
          armed_q <= 1'b0;
          evt_q   <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= key_raw_n[gi];
          sync2_q <= sync1_q;
          evt_q   <= 1'b0;
          if (!pressed) begin
            armed_q <= 1'b1;
          end
          if (pressed == lvl_q) begin
            cnt_q <= '0;
          end else if (cnt_q == DEB_LAST) begin
            cnt_q <= '0;
            lvl_q <= pressed;
            evt_q <= pressed & armed_q;
          end else begin
            cnt_q <= cnt_q + DW'(1);
          end
        end
      end

      assign key_evt[gi] = evt_q;
    end
  endgenerate

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [PW-1:0] div_q, div_d;
  logic [TW-1:0] sec_q, sec_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic          load_en_q, load_en_d;
  logic [1:0]    load_sel_q, load_sel_d;
  logic [5:0]    load_val_q, load_val_d;

  logic mode_evt;
  logic inc_evt;
  logic dec_evt;
  logic in_set;
  logic any_evt;
  logic adj_evt;
  logic timeout_hit;

  assign mode_evt    = key_evt[0];
  assign inc_evt     = key_evt[1];
  assign dec_evt     = key_evt[2];
  assign in_set      = (state_q != ST_RUN);
  assign any_evt     = |key_evt;
  assign adj_evt     = in_set && !mode_evt && (inc_evt ^ dec_evt);
  assign timeout_hit = in_set && !any_evt && (div_q == PRESC_LAST) && (sec_q == SEC_LAST);

  function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] max_v,
                                           input logic up);
    logic [5:0] r;
    if (up) begin
      r = (v >= max_v) ? 6'd0 : v + 6'd1;
    end else begin
      r = ((v == 6'd0) || (v > max_v)) ? max_v : v - 6'd1;
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    presc_d    = '0;
    tick_d     = 1'b0;
    div_d      = '0;
    sec_d      = '0;
    bcnt_d     = '0;
    phase_d    = 1'b0;
    load_en_d  = 1'b0;
    load_sel_d = load_sel_q;
    load_val_d = load_val_q;

    if (mode_evt) begin
      case (state_q)
        ST_RUN:  state_d = ST_HOUR;
        ST_HOUR: state_d = ST_MIN;
        ST_MIN:  state_d = ST_SEC;
        default: state_d = ST_RUN;
      endcase
    end else if (timeout_hit) begin
      state_d = ST_RUN;
    end

    // Prescaler restarts from 0 on the cycle RUN is re-entered
    if (state_q == ST_RUN && state_d == ST_RUN) begin
      if (presc_q == PRESC_LAST) begin
        tick_d = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    if (in_set && state_d == state_q && !any_evt) begin
      if (div_q == PRESC_LAST) begin
        sec_d = sec_q + TW'(1);
      end else begin
        div_d = div_q + PW'(1);
        sec_d = sec_q;
      end
    end

    if (in_set && state_d == state_q && !(inc_evt || dec_evt)) begin
      if (bcnt_q == BLINK_LAST) begin
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + BW'(1);
        phase_d = phase_q;
      end
    end

    if (adj_evt) begin
      load_en_d = 1'b1;
      case (state_q)
        ST_HOUR: begin
          load_sel_d = 2'b10;
          load_val_d = step_wrap({1'b0, cur_hour}, 6'd23, inc_evt);
        end
        ST_MIN: begin
          load_sel_d = 2'b01;
          load_val_d = step_wrap(cur_min, 6'd59, inc_evt);
        end
        default: begin
          load_sel_d = 2'b00;
          load_val_d = step_wrap(cur_sec, 6'd59, inc_evt);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      div_q      <= '0;
      sec_q      <= '0;
      bcnt_q     <= '0;
      phase_q    <= 1'b0;
      load_en_q  <= 1'b0;
      load_sel_q <= 2'b00;
      load_val_q <= 6'd0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      div_q      <= div_d;
      sec_q      <= sec_d;
      bcnt_q     <= bcnt_d;
      phase_q    <= phase_d;
      load_en_q  <= load_en_d;
      load_sel_q <= load_sel_d;
      load_val_q <= load_val_d;
    end
  end

  always_comb begin
    blank = 3'b000;
    case (state_q)
      ST_HOUR: blank[2] = phase_q;
      ST_MIN:  blank[1] = phase_q;
      ST_SEC:  blank[0] = phase_q;
      default: blank    = 3'b000;
    endcase
  end

  assign mode     = state_q;
  assign tick_1hz = tick_q;
  assign load_en  = load_en_q;
  assign load_sel = load_sel_q;
  assign load_val = load_val_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with small timing parameters
// (CLK_HZ=10, DEBOUNCE_CYCLES=4, BLINK_HALF=3, TIMEOUT_S=2).
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_mode_n = 1'b1;
  logic       key_inc_n = 1'b1;
  logic       key_dec_n = 1'b1;
  logic [4:0] cur_hour = 5'd0;
  logic [5:0] cur_min = 6'd0;
  logic [5:0] cur_sec = 6'd0;
  logic [1:0] mode;
  logic       tick_1hz;
  logic       load_en;
  logic [1:0] load_sel;
  logic [5:0] load_val;
  logic [2:0] blank;

  int tests_run = 0;
  int tests_failed = 0;

  clock_set_ctrl #(
    .CLK_HZ(10),
    .DEBOUNCE_CYCLES(4),
    .BLINK_HALF(3),
    .TIMEOUT_S(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_mode_n(key_mode_n),
    .key_inc_n(key_inc_n),
    .key_dec_n(key_dec_n),
    .cur_hour(cur_hour),
    .cur_min(cur_min),
    .cur_sec(cur_sec),
    .mode(mode),
    .tick_1hz(tick_1hz),
    .load_en(load_en),
    .load_sel(load_sel),
    .load_val(load_val),
    .blank(blank)
  );

  always #5 clk = ~clk;

  // One clock cycle; outputs are read and inputs driven 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    tests_run++;
    if (mode !== 2'b00 || tick_1hz !== 1'b0 || load_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: mode=%b tick=%b load_en=%b, want 00/0/0", mode, tick_1hz, load_en);
    end
    tests_run++;
    if (load_sel !== 2'b00 || load_val !== 6'd0 || blank !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_data: sel=%b val=%0d blank=%b, want 00/0/000", load_sel, load_val, blank);
    end
    rst = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_run_tick();
    logic exp_tick;
    for (int n = 1; n <= 35; n++) begin
      cyc();
      exp_tick = ((n % 10) == 0);
      tests_run++;
      if (tick_1hz !== exp_tick) begin
        tests_failed++;
        $display("FAIL run_tick cycle %0d: tick=%b want %b", n, tick_1hz, exp_tick);
      end
      tests_run++;
      if (mode !== 2'b00 || load_en !== 1'b0) begin
        tests_failed++;
        $display("FAIL run_state cycle %0d: mode=%b load_en=%b want 00/0", n, mode, load_en);
      end
    end
    $display("[TB] test_run_tick done");
  endtask

  task automatic test_debounce();
    key_mode_n = 1'b0;
    repeat (3) cyc();
    key_mode_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      cyc();
      tests_run++;
      if (mode !== 2'b00) begin
        tests_failed++;
        $display("FAIL bounce_mode cycle %0d: mode=%b want 00", n, mode);
      end
    end
    key_mode_n = 1'b0;
    repeat (6) cyc();
    tests_run++;
    if (mode !== 2'b00) begin
      tests_failed++;
      $display("FAIL press_early: mode=%b want 00 at cycle 6", mode);
    end
    cyc();
    tests_run++;
    if (mode !== 2'b01) begin
      tests_failed++;
      $display("FAIL press_mode: mode=%b want 01 at cycle 7", mode);
    end
    $display("[TB] test_debounce done");
  endtask

  task automatic test_load();
    key_mode_n = 1'b1;
    cur_hour   = 5'd23;
    key_inc_n  = 1'b0;
    repeat (6) cyc();
    tests_run++;
    if (load_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL hour_inc_early: load_en=%b want 0", load_en);
    end
    cyc();
    tests_run++;
    if (load_en !== 1'b1 || load_sel !== 2'b10 || load_val !== 6'd0 || mode !== 2'b01) begin
      tests_failed++;
      $display("FAIL hour_inc: en=%b sel=%b val=%0d mode=%b want 1/10/0/01",
               load_en, load_sel, load_val, mode);
    end
    cyc();
    tests_run++;
    if (load_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL hour_inc_single: load_en=%b want 0", load_en);
    end
    key_inc_n  = 1'b1;
    key_mode_n = 1'b0;
    repeat (7) cyc();
    tests_run++;
    if (mode !== 2'b10) begin
      tests_failed++;
      $display("FAIL to_set_min: mode=%b want 10", mode);
    end
    key_mode_n = 1'b1;
    cur_min    = 6'd0;
    key_dec_n  = 1'b0;
    repeat (7) cyc();
    tests_run++;
    if (load_en !== 1'b1 || load_sel !== 2'b01 || load_val !== 6'd59) begin
      tests_failed++;
      $display("FAIL min_dec: en=%b sel=%b val=%0d want 1/01/59", load_en, load_sel, load_val);
    end
    key_dec_n  = 1'b1;
    key_mode_n = 1'b0;
    repeat (7) cyc();
    tests_run++;
    if (mode !== 2'b11) begin
      tests_failed++;
      $display("FAIL to_set_sec: mode=%b want 11", mode);
    end
    $display("[TB] test_load done");
  endtask

  task automatic test_blink();
    logic [13:0] exp_blink;
    logic        exp_tick;
    exp_blink  = 14'b10001000111000;
    key_mode_n = 1'b1;
    cur_sec    = 6'd7;
    for (int s = 0; s <= 13; s++) begin
      if (s != 0) cyc();
      tests_run++;
      if (blank !== {2'b00, exp_blink[s]}) begin
        tests_failed++;
        $display("FAIL blink s=%0d: blank=%b want 00%b", s, blank, exp_blink[s]);
      end
      if (s == 3) key_inc_n = 1'b0;
      if (s == 9) begin
        tests_run++;
        if (load_en !== 1'b0) begin
          tests_failed++;
          $display("FAIL sec_inc_early: load_en=%b want 0", load_en);
        end
      end
      if (s == 10) begin
        tests_run++;
        if (load_en !== 1'b1 || load_sel !== 2'b00 || load_val !== 6'd8) begin
          tests_failed++;
          $display("FAIL sec_inc: en=%b sel=%b val=%0d want 1/00/8", load_en, load_sel, load_val);
        end
        key_inc_n  = 1'b1;
        key_mode_n = 1'b0;
      end
    end
    repeat (4) cyc();
    tests_run++;
    if (mode !== 2'b00 || blank !== 3'b000 || tick_1hz !== 1'b0) begin
      tests_failed++;
      $display("FAIL back_to_run: mode=%b blank=%b tick=%b want 00/000/0", mode, blank, tick_1hz);
    end
    key_mode_n = 1'b1;
    for (int s = 18; s <= 27; s++) begin
      cyc();
      exp_tick = (s == 27);
      tests_run++;
      if (tick_1hz !== exp_tick) begin
        tests_failed++;
        $display("FAIL first_tick s=%0d: tick=%b want %b", s, tick_1hz, exp_tick);
      end
    end
    $display("[TB] test_blink done");
  endtask

  task automatic test_timeout();
    key_mode_n = 1'b0;
    repeat (7) cyc();
    tests_run++;
    if (mode !== 2'b01) begin
      tests_failed++;
      $display("FAIL to_hour: mode=%b want 01", mode);
    end
    key_mode_n = 1'b1;
    repeat (7) cyc();
    key_mode_n = 1'b0;
    repeat (7) cyc();
    tests_run++;
    if (mode !== 2'b10) begin
      tests_failed++;
      $display("FAIL to_min: mode=%b want 10", mode);
    end
    key_mode_n = 1'b1;
    for (int m = 1; m <= 20; m++) begin
      cyc();
      tests_run++;
      if (load_en !== 1'b0) begin
        tests_failed++;
        $display("FAIL timeout_noload m=%0d: load_en=%b want 0", m, load_en);
      end
      if (m == 19) begin
        tests_run++;
        if (mode !== 2'b10) begin
          tests_failed++;
          $display("FAIL timeout_early: mode=%b want 10", mode);
        end
      end
      if (m == 20) begin
        tests_run++;
        if (mode !== 2'b00) begin
          tests_failed++;
          $display("FAIL timeout_run: mode=%b want 00", mode);
        end
      end
    end
    $display("[TB] test_timeout done");
  endtask

  task automatic test_inc_dec_same();
    key_mode_n = 1'b0;
    repeat (7) cyc();
    tests_run++;
    if (mode !== 2'b01) begin
      tests_failed++;
      $display("FAIL incdec_entry: mode=%b want 01", mode);
    end
    key_mode_n = 1'b1;
    key_inc_n  = 1'b0;
    key_dec_n  = 1'b0;
    for (int h = 1; h <= 10; h++) begin
      cyc();
      tests_run++;
      if (load_en !== 1'b0 || mode !== 2'b01) begin
        tests_failed++;
        $display("FAIL incdec_ignored h=%0d: load_en=%b mode=%b want 0/01", h, load_en, mode);
      end
      if (h == 7) begin
        key_inc_n  = 1'b1;
        key_dec_n  = 1'b1;
        key_mode_n = 1'b0;
      end
    end
    repeat (4) cyc();
    tests_run++;
    if (mode !== 2'b10) begin
      tests_failed++;
      $display("FAIL incdec_to_min: mode=%b want 10", mode);
    end
    $display("[TB] test_inc_dec_same done");
  endtask

  task automatic test_reset_mid_set();
    logic [2:0] exp_blank;
    key_inc_n = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      cyc();
      exp_blank = (n >= 3) ? 3'b010 : 3'b000;
      tests_run++;
      if (blank !== exp_blank) begin
        tests_failed++;
        $display("FAIL min_blink n=%0d: blank=%b want %b", n, blank, exp_blank);
      end
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (mode !== 2'b00 || tick_1hz !== 1'b0 || load_en !== 1'b0 || load_sel !== 2'b00 ||
        load_val !== 6'd0 || blank !== 3'b000) begin
      tests_failed++;
      $display("FAIL async_reset: mode=%b tick=%b en=%b sel=%b val=%0d blank=%b want all 0",
               mode, tick_1hz, load_en, load_sel, load_val, blank);
    end
    cyc();
    cyc();
    rst = 1'b0;
    for (int r = 1; r <= 14; r++) begin
      cyc();
      tests_run++;
      if (mode !== 2'b00 || load_en !== 1'b0) begin
        tests_failed++;
        $display("FAIL held_after_reset r=%0d: mode=%b load_en=%b want 00/0", r, mode, load_en);
      end
    end
    key_mode_n = 1'b1;
    key_inc_n  = 1'b1;
    repeat (8) cyc();
    key_mode_n = 1'b0;
    repeat (6) cyc();
    tests_run++;
    if (mode !== 2'b00) begin
      tests_failed++;
      $display("FAIL repress_early: mode=%b want 00", mode);
    end
    cyc();
    tests_run++;
    if (mode !== 2'b01) begin
      tests_failed++;
      $display("FAIL repress_mode: mode=%b want 01", mode);
    end
    key_mode_n = 1'b1;
    $display("[TB] test_reset_mid_set done");
  endtask

  initial begin
    test_reset();
    test_run_tick();
    test_debounce();
    test_load();
    test_blink();
    test_timeout();
    test_inc_dec_same();
    test_reset_mid_set();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
